mcycle_ctrl: RTL and testbench

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

---
 rtl/mcycle_ctrl_if.sv | 47 ++++
 rtl/mcycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mcycle_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// mcycle_ctrl_if
// Bundle between the multicycle controller and its datapath/memory.
//   op_i        : opcode field of the instruction register (datapath -> ctrl)
//   zero_i      : ALU zero flag (datapath -> ctrl)
//   memready_i  : memory finishes the current read/write this cycle
//   memread_o .. irwrite_o           : 1-bit datapath strobes and selects
//   pcsource_o, alusrcb_o, aluop_o   : 2-bit mux selects / ALU op class
//   state_o     : current controller state, for debug
//   trap_o      : sticky halt flag
//   trapcause_o : 0 = illegal opcode, 1 = memory timeout (valid with trap_o)
// master = datapath side, slave = controller side.
// ---------------------------------------------------------------------------
interface mcycle_ctrl_if;
  logic [5:0] op_i;
  logic       zero_i;
  logic       memready_i;
  logic       memread_o;
  logic       memwrite_o;
  logic       alusrca_o;
  logic       memtoreg_o;
  logic       iord_o;
  logic       pcen_o;
  logic       regwrite_o;
  logic       regdst_o;
  logic       irwrite_o;
  logic [1:0] pcsource_o;
  logic [1:0] alusrcb_o;
  logic [1:0] aluop_o;
  logic [3:0] state_o;
  logic       trap_o;
  logic       trapcause_o;

  modport master (
    output op_i, zero_i, memready_i,
    input  memread_o, memwrite_o, alusrca_o, memtoreg_o, iord_o, pcen_o,
           regwrite_o, regdst_o, irwrite_o, pcsource_o, alusrcb_o, aluop_o,
           state_o, trap_o, trapcause_o
  );

  modport slave (
    input  op_i, zero_i, memready_i,
    output memread_o, memwrite_o, alusrca_o, memtoreg_o, iord_o, pcen_o,
           regwrite_o, regdst_o, irwrite_o, pcsource_o, alusrcb_o, aluop_o,
           state_o, trap_o, trapcause_o
  );
endinterface

// File: rtl/mcycle_ctrl.sv
// ---------------------------------------------------------------------------
// mcycle_ctrl
// Multicycle MIPS-style control FSM with memory wait handling, a per-access
// not-ready timeout and a sticky trap state (illegal opcode / timeout).
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : mcycle_ctrl_if.slave -- opcode, zero flag, memready in;
//         datapath strobes/selects, debug state and trap status out
// Parameters:
//   MEM_TIMEOUT  : allowed consecutive not-ready cycles per access (0 = none)
//   SUPPORT_BNE  : 1 decodes bne, 0 treats it as illegal
//   SUPPORT_ADDI : 1 decodes addi, 0 treats it as illegal
// ---------------------------------------------------------------------------
module mcycle_ctrl #(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit SUPPORT_BNE  = 1'b1,
  parameter bit SUPPORT_ADDI = 1'b1
) (
  input logic         clk,
  input logic         rst,
  mcycle_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7,
    S_BREX    = 4'd8,  S_JEX     = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_TRAP    = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Count value seen on the last tolerated not-ready cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             is_sw_q, is_sw_d;
  logic             is_bne_q, is_bne_d;
  logic             cause_q, cause_d;
  logic             waiting;

  logic       memread, memwrite, alusrca, memtoreg, iord, pcen;
  logic       regwrite, regdst, irwrite;
  logic [1:0] pcsource, alusrcb, aluop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      cause_q    <= 1'b0;
      is_sw_q    <= 1'b0;
      is_bne_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
      is_sw_q    <= is_sw_d;
      is_bne_q   <= is_bne_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    cause_d    = cause_q;
    is_sw_d    = is_sw_q;
    is_bne_d   = is_bne_q;
    waiting    = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    memtoreg   = 1'b0;
    iord       = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    irwrite    = 1'b0;
    pcsource   = 2'b00;
    alusrcb    = 2'b00;
    aluop      = 2'b00;

    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = bus.memready_i;
        pcen    = bus.memready_i;
        waiting = 1'b1;
        if (bus.memready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb  = 2'b11;
        // Latch the op class so later states ignore op_i.
        is_sw_d  = (bus.op_i == OP_SW);
        is_bne_d = (bus.op_i == OP_BNE);
        if (bus.op_i == OP_LW || bus.op_i == OP_SW)                   state_d = S_MEMADR;
        else if (bus.op_i == OP_R)                                    state_d = S_RTYPEEX;
        else if (bus.op_i == OP_BEQ || (SUPPORT_BNE && bus.op_i == OP_BNE)) state_d = S_BREX;
        else if (bus.op_i == OP_J)                                    state_d = S_JEX;
        else if (SUPPORT_ADDI && bus.op_i == OP_ADDI)                 state_d = S_ADDIEX;
        else begin
          state_d = S_TRAP;
          cause_d = 1'b0;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        waiting = 1'b1;
        if (bus.memready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        waiting  = 1'b1;
        if (bus.memready_i) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BREX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsource = 2'b01;
        pcen     = is_bne_q ? ~bus.zero_i : bus.zero_i;
        state_d  = S_FETCH;
      end
      S_JEX: begin
        pcsource = 2'b10;
        pcen     = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Counter is zero outside wait states and on any ready cycle, so it is
    // already clear whenever a wait state is entered.
    if (waiting && !bus.memready_i) begin
      wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;
      if (MEM_TIMEOUT > 0 && wait_cnt_q >= CNT_LAST) begin
        state_d = S_TRAP;
        cause_d = 1'b1;
      end
    end
  end

  assign bus.memread_o   = memread  & ~rst;
  assign bus.memwrite_o  = memwrite & ~rst;
  assign bus.alusrca_o   = alusrca  & ~rst;
  assign bus.memtoreg_o  = memtoreg & ~rst;
  assign bus.iord_o      = iord     & ~rst;
  assign bus.pcen_o      = pcen     & ~rst;
  assign bus.regwrite_o  = regwrite & ~rst;
  assign bus.regdst_o    = regdst   & ~rst;
  assign bus.irwrite_o   = irwrite  & ~rst;
  assign bus.pcsource_o  = pcsource & {2{~rst}};
  assign bus.alusrcb_o   = alusrcb  & {2{~rst}};
  assign bus.aluop_o     = aluop    & {2{~rst}};
  assign bus.state_o     = state_q;
  assign bus.trap_o      = (state_q == S_TRAP);
  assign bus.trapcause_o = cause_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
module tb_mcycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [20:0] SMASK  = 21'h1FFFC0;

  typedef struct packed {
    logic memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst, irwrite;
    logic [1:0] pcsource, alusrcb, aluop;
    logic trap, trapcause;
    logic [3:0] state;
  } obs_t;

  typedef struct {
    bit rst; logic [5:0] op; bit zero; bit rdy; obs_t exp;
  } step_t;

  typedef struct {
    bit rst; logic [5:0] op; bit zero; bit rdy;
    logic [3:0] st; bit mr, mw, io, irw, pc, rw, tr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic [5:0] op;
  logic zero, rdy;
  int n_checks = 0;
  int n_pass = 0;
  int mt;
  bit bne_en, addi_en;
  step_t q[$];
  vec_t tbl[$];

  mcycle_ctrl_if ifa ();
  mcycle_ctrl_if ifb ();
  mcycle_ctrl_if ifc ();

  assign ifa.op_i = op; assign ifa.zero_i = zero; assign ifa.memready_i = rdy;
  assign ifb.op_i = op; assign ifb.zero_i = zero; assign ifb.memready_i = rdy;
  assign ifc.op_i = op; assign ifc.zero_i = zero; assign ifc.memready_i = rdy;

  mcycle_ctrl #(.MEM_TIMEOUT(16), .SUPPORT_BNE(1'b1), .SUPPORT_ADDI(1'b1))
    dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  mcycle_ctrl #(.MEM_TIMEOUT(4), .SUPPORT_BNE(1'b0), .SUPPORT_ADDI(1'b0))
    dut_b (.clk(clk), .rst(rst_b), .bus(ifb));
  mcycle_ctrl #(.MEM_TIMEOUT(0), .SUPPORT_BNE(1'b1), .SUPPORT_ADDI(1'b1))
    dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {ifa.memread_o, ifa.memwrite_o, ifa.alusrca_o, ifa.memtoreg_o, ifa.iord_o,
                  ifa.pcen_o, ifa.regwrite_o, ifa.regdst_o, ifa.irwrite_o, ifa.pcsource_o,
                  ifa.alusrcb_o, ifa.aluop_o, ifa.trap_o, ifa.trapcause_o, ifa.state_o};
  assign obs_b = {ifb.memread_o, ifb.memwrite_o, ifb.alusrca_o, ifb.memtoreg_o, ifb.iord_o,
                  ifb.pcen_o, ifb.regwrite_o, ifb.regdst_o, ifb.irwrite_o, ifb.pcsource_o,
                  ifb.alusrcb_o, ifb.aluop_o, ifb.trap_o, ifb.trapcause_o, ifb.state_o};
  assign obs_c = {ifc.memread_o, ifc.memwrite_o, ifc.alusrca_o, ifc.memtoreg_o, ifc.iord_o,
                  ifc.pcen_o, ifc.regwrite_o, ifc.regdst_o, ifc.irwrite_o, ifc.pcsource_o,
                  ifc.alusrcb_o, ifc.aluop_o, ifc.trap_o, ifc.trapcause_o, ifc.state_o};

  // Expected outputs of one cycle, from the per-state output table.
  function automatic obs_t model_obs(int st, bit r, bit z, bit bne, bit cause);
    obs_t o;
    o = '0;
    o.state = 4'(st);
    case (st)
      0:  begin o.memread = 1; o.alusrcb = 2'b01; o.irwrite = r; o.pcen = r; end
      1:  o.alusrcb = 2'b11;
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      3:  begin o.memread = 1; o.iord = 1; end
      4:  begin o.memtoreg = 1; o.regwrite = 1; end
      5:  begin o.memwrite = 1; o.iord = 1; end
      6:  begin o.alusrca = 1; o.aluop = 2'b10; end
      7:  begin o.regdst = 1; o.regwrite = 1; end
      8:  begin o.alusrca = 1; o.aluop = 2'b01; o.pcsource = 2'b01; o.pcen = bne ? ~z : z; end
      9:  begin o.pcsource = 2'b10; o.pcen = 1; end
      10: begin o.alusrca = 1; o.alusrcb = 2'b10; end
      11: o.regwrite = 1;
      15: begin o.trap = 1; o.trapcause = cause; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic bit rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic void push(int st, bit r, logic [5:0] o, bit z, bit bne, bit cause);
    step_t s;
    s.rst = 0; s.op = o; s.zero = z; s.rdy = r;
    s.exp = model_obs(st, r, z, bne, cause);
    q.push_back(s);
  endfunction

  function automatic void push_rst();
    step_t s;
    s.rst = 1; s.op = rop(); s.zero = rbit(); s.rdy = rbit(); s.exp = '0;
    q.push_back(s);
  endfunction

  function automatic void push_trap(bit cause);
    push(15, rbit(), rop(), rbit(), 0, cause);
    push(15, rbit(), rop(), rbit(), 0, cause);
    push_rst();
  endfunction

  // A memory access that sees `waits` not-ready cycles; returns 1 if it times out.
  function automatic bit push_wait(int st, int waits);
    if (mt > 0 && waits >= mt) begin
      for (int i = 0; i < mt; i++) push(st, 0, rop(), rbit(), 0, 0);
      return 1'b1;
    end
    for (int i = 0; i < waits; i++) push(st, 0, rop(), rbit(), 0, 0);
    push(st, 1, rop(), rbit(), 0, 0);
    return 1'b0;
  endfunction

  // Instruction-level model: the cycle sequence one instruction produces.
  function automatic void gen_instr(logic [5:0] opc, int fw, int mw);
    if (push_wait(0, fw)) begin push_trap(1); return; end
    push(1, rbit(), opc, rbit(), 0, 0);
    case (opc)
      OP_R:   begin push(6, rbit(), rop(), rbit(), 0, 0); push(7, rbit(), rop(), rbit(), 0, 0); end
      OP_LW:  begin
        push(2, rbit(), rop(), rbit(), 0, 0);
        if (push_wait(3, mw)) push_trap(1);
        else push(4, rbit(), rop(), rbit(), 0, 0);
      end
      OP_SW:  begin
        push(2, rbit(), rop(), rbit(), 0, 0);
        if (push_wait(5, mw)) push_trap(1);
      end
      OP_BEQ: push(8, rbit(), rop(), rbit(), 0, 0);
      OP_BNE: if (bne_en) push(8, rbit(), rop(), rbit(), 1, 0); else push_trap(0);
      OP_J:   push(9, rbit(), rop(), rbit(), 0, 0);
      OP_ADDI: if (addi_en) begin
        push(10, rbit(), rop(), rbit(), 0, 0);
        push(11, rbit(), rop(), rbit(), 0, 0);
      end else push_trap(0);
      default: push_trap(0);
    endcase
  endfunction

  function automatic void check(string name, int idx, logic [20:0] got, logic [20:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
  endfunction

  task automatic run_q(input int sel, input string name);
    obs_t got;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      op = q[i].op; zero = q[i].zero; rdy = q[i].rdy;
      case (sel)
        0: rst_a = q[i].rst;
        1: rst_b = q[i].rst;
        default: rst_c = q[i].rst;
      endcase
      #1;
      got = (sel == 0) ? obs_a : (sel == 1) ? obs_b : obs_c;
      if (q[i].rst) check(name, i, got & SMASK, '0);
      else check(name, i, got, q[i].exp);
    end
    q.delete();
  endtask

  function automatic vec_t V(bit r, logic [5:0] o, bit z, bit rd, logic [3:0] s,
                             bit mr, bit mw, bit io, bit irw, bit pc, bit rw, bit tr);
    vec_t v;
    v.rst = r; v.op = o; v.zero = z; v.rdy = rd; v.st = s;
    v.mr = mr; v.mw = mw; v.io = io; v.irw = irw; v.pc = pc; v.rw = rw; v.tr = tr;
    return v;
  endfunction

  initial begin
    logic [10:0] g, e, m;
    logic [5:0] ill [4];
    rst_a = 1; rst_b = 1; rst_c = 1; op = '0; zero = 0; rdy = 0;
    ill[0] = 6'b111111; ill[1] = 6'b000001; ill[2] = 6'b100000; ill[3] = 6'b001001;

    //               rst op     z rdy st  mr mw io irw pc rw tr
    tbl.push_back(V(1, OP_R,   0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 0,  1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_LW,  0, 1, 6,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_LW,  0, 1, 7,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(V(0, OP_LW,  0, 1, 0,  1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, OP_LW,  0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 2,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 0, 3,  1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 0, 3,  1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 0, 3,  1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 3,  1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 4,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(V(0, OP_R,   0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 0,  1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, OP_BEQ, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_BNE, 1, 1, 8,  0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 0,  1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, OP_BNE, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_BEQ, 1, 1, 8,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 0,  1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, OP_SW,  0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_LW,  0, 1, 2,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 0, 5,  0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 5,  0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 0,  1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, OP_J,   0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 9,  0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 0,  1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, OP_ADDI,0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 10, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 11, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 0,  1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, 6'h3f,  0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 15, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(V(0, OP_R,   0, 1, 15, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(V(1, OP_R,   0, 1, 15, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 0,  1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, OP_SW,  0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 2,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 0, 5,  0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(V(1, OP_R,   0, 0, 5,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, OP_R,   0, 1, 0,  1, 0, 0, 1, 1, 0, 0));

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      op = tbl[i].op; zero = tbl[i].zero; rdy = tbl[i].rdy; rst_a = tbl[i].rst;
      #1;
      g = {obs_a.state, obs_a.memread, obs_a.memwrite, obs_a.iord, obs_a.irwrite,
           obs_a.pcen, obs_a.regwrite, obs_a.trap};
      e = {tbl[i].st, tbl[i].mr, tbl[i].mw, tbl[i].io, tbl[i].irw,
           tbl[i].pc, tbl[i].rw, tbl[i].tr};
      m = tbl[i].rst ? 11'b0000_1111110 : 11'h7ff;
      check("table", i, 21'(g & m), 21'(e & m));
    end

    // Random instruction stream, default configuration.
    mt = 16; bne_en = 1; addi_en = 1;
    push_rst();
    for (int n = 0; n < 250; n++) begin
      int k, fw, mw;
      logic [5:0] opc;
      k = $urandom_range(0, 7);
      case (k)
        0: opc = OP_R;   1: opc = OP_LW;  2: opc = OP_SW;  3: opc = OP_BEQ;
        4: opc = OP_BNE; 5: opc = OP_J;   6: opc = OP_ADDI;
        default: opc = ill[$urandom_range(0, 3)];
      endcase
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 3);
      gen_instr(opc, fw, mw);
    end
    run_q(0, "random");

    // MEM_TIMEOUT=4, bne/addi disabled.
    mt = 4; bne_en = 0; addi_en = 0;
    push_rst();
    gen_instr(OP_BNE, 0, 0);
    gen_instr(OP_R, 10, 0);
    gen_instr(OP_ADDI, 1, 0);
    gen_instr(OP_LW, 1, 4);
    gen_instr(OP_SW, 3, 3);
    gen_instr(OP_LW, 3, 3);
    gen_instr(OP_BEQ, 0, 0);
    run_q(1, "timeout4");

    // MEM_TIMEOUT=0: waits are unbounded.
    mt = 0; bne_en = 1; addi_en = 1;
    push_rst();
    gen_instr(OP_R, 40, 0);
    gen_instr(OP_LW, 0, 35);
    gen_instr(OP_SW, 2, 20);
    gen_instr(OP_BNE, 0, 0);
    run_q(2, "notimeout");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
